// File: rtl/syscall_dispatch_pkg.sv
// rtl/syscall_dispatch_pkg.sv - shared encodings for the syscall dispatch front end
//
// Purpose: MIPS field encodings, register numbers and dispatch FSM states
// used by syscall_dispatch and its drain counter.
// Ports: none (package).
package syscall_dispatch_pkg;

  localparam logic [5:0] OP_SPECIAL    = 6'h00;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
  localparam logic [4:0] REG_V0        = 5'd2;
  localparam logic [4:0] REG_A0        = 5'd4;

  typedef enum logic [1:0] {
    SD_IDLE  = 2'd0,
    SD_DRAIN = 2'd1,
    SD_READ  = 2'd2,
    SD_ISSUE = 2'd3
  } sd_state_t;

  // The 20-bit code field (bits 25:6) plays no part in recognising a syscall.
  function automatic logic is_syscall(input logic [31:0] word);
    return (word[31:26] == OP_SPECIAL) && (word[5:0] == FUNCT_SYSCALL);
  endfunction

endpackage

// File: rtl/syscall_dispatch_drain.sv
// rtl/syscall_dispatch_drain.sv - saturating drain-wait counter with terminal flag
//
// Purpose: counts cycles spent waiting for older register writes to drain.
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   clr   in   return the count to zero
//   en    in   count this cycle
//   hit   out  this enabled cycle is the MAX-th one (count is about to reach MAX)
module sat_drain_counter #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] LAST = W'(MAX - 1);
  localparam logic [W-1:0] TOP  = W'(MAX);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TOP)) begin
      count <= count + 1'b1;
    end
  end

  // Flag the cycle whose increment lands on MAX so the FSM can leave DRAIN
  // on the same edge the limit is reached.
  assign hit = en && (count == LAST);

endmodule

// File: rtl/syscall_dispatch.sv
// rtl/syscall_dispatch.sv - detects SYSCALL in decode, drains, reads $v0/$a0, strobes system_call
//
// Purpose: stall the front end on a SYSCALL until older writes retire, fetch
// $v0/$a0 through a dedicated read-port pair and hand them downstream with a
// one-cycle syscall_control strobe.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   inst, inst_valid           decode-stage instruction and its valid bit
//   wb_busy                    an older register write is still pending
//   rf_raddr_a/b, rf_rdata_a/b register-file read port pair (combinational read)
//   stall                      freeze PC and IF/ID
//   syscall_control            one-cycle strobe to system_call
//   v0, a0, sc_inst            latched operands and syscall word
//   syscall_count              syscalls issued, wrapping
//   drain_timeout              sticky: drain wait hit DRAIN_MAX
module syscall_dispatch
  import syscall_dispatch_pkg::*;
#(
  parameter int DRAIN_MAX = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  input  logic             wb_busy,
  output logic [4:0]       rf_raddr_a,
  output logic [4:0]       rf_raddr_b,
  input  logic [31:0]      rf_rdata_a,
  input  logic [31:0]      rf_rdata_b,
  output logic             stall,
  output logic             syscall_control,
  output logic [31:0]      v0,
  output logic [31:0]      a0,
  output logic [31:0]      sc_inst,
  output logic [CNT_W-1:0] syscall_count,
  output logic             drain_timeout
);

  sd_state_t state, state_nxt;
  logic      detect;
  logic      drain_clr, drain_en, drain_hit, set_timeout;

  assign detect = inst_valid && is_syscall(inst);

  sat_drain_counter #(.MAX(DRAIN_MAX)) u_drain (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (drain_clr),
    .en    (drain_en),
    .hit   (drain_hit)
  );

  always_comb begin
    state_nxt       = state;
    stall           = 1'b0;
    syscall_control = 1'b0;
    rf_raddr_a      = 5'd0;
    rf_raddr_b      = 5'd0;
    drain_clr       = 1'b0;
    drain_en        = 1'b0;
    set_timeout     = 1'b0;
    case (state)
      SD_IDLE: begin
        // Stall in the detect cycle itself so the syscall never leaves decode.
        stall = detect;
        if (detect) begin
          drain_clr = 1'b1;
          state_nxt = SD_DRAIN;
        end
      end
      SD_DRAIN: begin
        stall = 1'b1;
        if (!wb_busy) begin
          state_nxt = SD_READ;
        end else begin
          drain_en = 1'b1;
          if (drain_hit) begin
            set_timeout = 1'b1;
            state_nxt   = SD_READ;
          end
        end
      end
      SD_READ: begin
        stall      = 1'b1;
        rf_raddr_a = REG_V0;
        rf_raddr_b = REG_A0;
        state_nxt  = SD_ISSUE;
      end
      SD_ISSUE: begin
        stall           = 1'b1;
        syscall_control = 1'b1;
        state_nxt       = SD_IDLE;
      end
      default: state_nxt = SD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= SD_IDLE;
      v0            <= '0;
      a0            <= '0;
      sc_inst       <= '0;
      syscall_count <= '0;
      drain_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == SD_IDLE && detect) begin
        sc_inst <= inst;
      end
      if (state == SD_READ) begin
        v0 <= rf_rdata_a;
        a0 <= rf_rdata_b;
      end
      if (state == SD_ISSUE) begin
        syscall_count <= syscall_count + 1'b1;
      end
      if (set_timeout) begin
        drain_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_syscall_dispatch.sv
// tb/tb_syscall_dispatch.sv - scoreboard bench for syscall_dispatch
module tb_syscall_dispatch;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_valid;
  logic        wb_busy;
  logic [4:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic        stall, syscall_control;
  logic [31:0] v0, a0, sc_inst;
  logic [3:0]  syscall_count;
  logic        drain_timeout;

  logic [31:0] regs [32];
  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];

  syscall_dispatch #(.DRAIN_MAX(16), .CNT_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .wb_busy         (wb_busy),
    .rf_raddr_a      (rf_raddr_a),
    .rf_raddr_b      (rf_raddr_b),
    .rf_rdata_a      (rf_rdata_a),
    .rf_rdata_b      (rf_rdata_b),
    .stall           (stall),
    .syscall_control (syscall_control),
    .v0              (v0),
    .a0              (a0),
    .sc_inst         (sc_inst),
    .syscall_count   (syscall_count),
    .drain_timeout   (drain_timeout)
  );

  typedef struct {
    int          iss;
    logic [31:0] v0;
    logic [31:0] a0;
    logic [31:0] ins;
    logic [3:0]  cnt;
    logic        to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int         applied = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [3:0] exp_cnt;
  logic       exp_to;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (syscall_control === 1'b1) begin
      if (sb.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("issue_cycle", 32'(cyc), 32'(mon_e.iss));
        check("v0", v0, mon_e.v0);
        check("a0", a0, mon_e.a0);
        check("sc_inst", sc_inst, mon_e.ins);
        check("count_at_issue", 32'(syscall_count), 32'(mon_e.cnt));
        check("drain_timeout", 32'(drain_timeout), 32'(mon_e.to));
      end
    end
  end

  // Entered and left just after a posedge. busy = DRAIN cycles with wb_busy high.
  task automatic run_sc(input logic [31:0] w, input int busy);
    int   n, iss, eff;
    exp_t e;
    inst       = w;
    inst_valid = 1'b1;
    wb_busy    = (busy > 0);
    n   = cyc;
    eff = (busy > 15) ? 15 : busy;
    iss = n + 3 + eff;
    if (busy >= 16) exp_to = 1'b1;
    e.iss = iss; e.v0 = regs[2]; e.a0 = regs[4]; e.ins = w; e.cnt = exp_cnt; e.to = exp_to;
    sb.push_back(e);
    @(negedge clk);
    check("stall_detect", 32'(stall), 32'd1);
    @(posedge clk); #1;
    inst       = 32'h0;
    inst_valid = 1'b0;
    for (int k = 1; k <= iss - n; k++) begin
      wb_busy = (k <= busy);
      @(negedge clk);
      check("stall_seq", 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    wb_busy = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    check("stall_release", 32'(stall), 32'd0);
    check("count_after", 32'(syscall_count), 32'(exp_cnt));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_strobe"}, 32'(syscall_control), 32'd0);
    check({tag, "_v0"}, v0, 32'd0);
    check({tag, "_a0"}, a0, 32'd0);
    check({tag, "_sc_inst"}, sc_inst, 32'd0);
    check({tag, "_count"}, 32'(syscall_count), 32'd0);
    check({tag, "_timeout"}, 32'(drain_timeout), 32'd0);
    check({tag, "_raddr_a"}, 32'(rf_raddr_a), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 | 32'(i);
    exp_cnt    = 4'd0;
    exp_to     = 1'b0;
    rst_n      = 1'b0;
    inst       = 32'h0;
    inst_valid = 1'b0;
    wb_busy    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: no drain wait.
    regs[2] = 32'd1; regs[4] = 32'd42;
    run_sc(32'h0000_000C, 0);

    // Drain wait of 5 cycles, no timeout.
    regs[2] = 32'h0000_000A; regs[4] = 32'hDEAD_BEEF;
    run_sc(32'h0000_000C, 5);

    // Non-syscalls: BREAK, J with funct bits 0x0C, syscall word while invalid.
    inst = 32'h0000_000D; inst_valid = 1'b1;
    @(negedge clk); check("break_no_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    inst = 32'h0800_000C;
    @(negedge clk); check("jump_no_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    inst = 32'h0000_000C; inst_valid = 1'b0;
    @(negedge clk); check("invalid_no_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    inst = 32'h0;

    // Syscall carrying a nonzero code field.
    regs[2] = 32'h1234_5678; regs[4] = 32'h8765_4321;
    run_sc(32'h0040_000C, 0);

    // Exactly 15 busy DRAIN cycles: longest wait that does not time out.
    regs[2] = 32'h0000_0015; regs[4] = 32'h0000_0F0F;
    run_sc(32'h0000_000C, 15);

    // Stuck wb_busy: timeout after 16 DRAIN cycles, strobe still issued.
    regs[2] = 32'h5555_0001; regs[4] = 32'hAAAA_0002;
    run_sc(32'h0000_000C, 20);

    // Flag stays sticky through a later clean syscall.
    regs[2] = 32'h0000_0007; regs[4] = 32'h0000_0009;
    run_sc(32'h03FF_FFCC, 2);

    // Reset pulsed during READ: no strobe, everything cleared.
    regs[2] = 32'hFFFF_0000; regs[4] = 32'h0000_FFFF;
    inst = 32'h0000_000C; inst_valid = 1'b1; wb_busy = 1'b0;
    @(posedge clk); #1;
    inst = 32'h0; inst_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("read_raddr_a", 32'(rf_raddr_a), 32'd2);
    check("read_raddr_b", 32'(rf_raddr_b), 32'd4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    exp_to  = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    repeat (6) @(posedge clk);
    #1;
    check("midreset_v0_hold", v0, 32'd0);

    // Wrap: 17 syscalls on a 4-bit counter end at 1.
    for (int i = 0; i < 17; i++) begin
      regs[2] = 32'(i);
      regs[4] = 32'(i * 3);
      run_sc(32'h0000_000C | (32'(i) << 6), i % 3);
    end
    @(negedge clk);
    check("count_wrap", 32'(syscall_count), 32'd1);

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    check("pending_strobes", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
